// File: rtl/bhg_psg_pkg.sv
// rtl/bhg_psg_pkg.sv - shared constants, slot sizing and log-to-linear table generator for the PSG mixer
package bhg_psg_pkg;
  localparam int LOG_BITS  = 5;
  localparam int LOG_CODES = 1 << LOG_BITS;

  // Width of the slot index for a given channel count (slots run 0..channels)
  function automatic int slot_bits(input int channels);
    return (channels < 1) ? 1 : $clog2(channels + 1);
  endfunction

  // Each code below full scale is 1.5 dB quieter; code 0 is hard silence
  function automatic int lin_level(input int dac_bits, input int code);
    real full;
    real r;
    full = (2.0 ** dac_bits) - 1.0;
    if (code <= 0) return 0;
    if (code >= LOG_CODES - 1) return (1 << dac_bits) - 1;
    r = full * (10.0 ** (-(real'(LOG_CODES - 1 - code)) * 1.5 / 20.0));
    return $rtoi(r + 0.5);
  endfunction
endpackage

// File: rtl/bhg_psg_mixer_if.sv
// rtl/bhg_psg_mixer_if.sv - channel inputs and mixed outputs of the PSG mixer
interface bhg_psg_mixer_if
  import bhg_psg_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DAC_BITS = 10
);
  localparam int SUM_BITS = DAC_BITS + $clog2(CHANNELS + 1);

  logic                         clk_en;
  logic [LOG_BITS*CHANNELS-1:0] log_in;
  logic [CHANNELS-1:0]          pan_l;
  logic [CHANNELS-1:0]          pan_r;
  logic [3:0]                   master_att;
  logic [DAC_BITS*CHANNELS-1:0] chan_lin;
  logic [SUM_BITS-1:0]          left;
  logic [SUM_BITS-1:0]          right;
  logic                         sample_stb;

  modport master (
    output clk_en, log_in, pan_l, pan_r, master_att,
    input  chan_lin, left, right, sample_stb
  );

  modport slave (
    input  clk_en, log_in, pan_l, pan_r, master_att,
    output chan_lin, left, right, sample_stb
  );
endinterface

// File: rtl/bhg_psg_log2lin.sv
// rtl/bhg_psg_log2lin.sv - registered 32-entry log-to-linear ROM, one-enable latency
module bhg_psg_log2lin
  import bhg_psg_pkg::*;
#(
  parameter int DAC_BITS = 10
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clk_en,
  input  logic [LOG_BITS-1:0] addr,
  output logic [DAC_BITS-1:0] data
);
  logic [DAC_BITS-1:0] rom [LOG_CODES];

  for (genvar i = 0; i < LOG_CODES; i++) begin : g_rom
    assign rom[i] = DAC_BITS'(lin_level(DAC_BITS, i));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
    end else if (clk_en) begin
      data <= rom[addr];
    end
  end
endmodule

// File: rtl/bhg_psg_mixer.sv
// rtl/bhg_psg_mixer.sv - N-channel time-multiplexed log-volume mixer with stereo pan sums
// Define BHG_PSG_MASTER_ATT_EN to apply master_att before the table lookup.
module bhg_psg_mixer
  import bhg_psg_pkg::*;
#(
  parameter int CHANNELS = 3,
  parameter int DAC_BITS = 10
) (
  input logic           clk,
  input logic           rst_n,
  bhg_psg_mixer_if.slave bus
);
  localparam int SUM_BITS = DAC_BITS + $clog2(CHANNELS + 1);
  localparam int SB       = slot_bits(CHANNELS);
  typedef logic [SB-1:0] slot_t;
  localparam slot_t LAST  = slot_t'(CHANNELS);

  slot_t                        slot;
  logic                         primed;
  logic [LOG_BITS-1:0]          code;
  logic [LOG_BITS-1:0]          eff;
  logic                         rom_en;
  logic [DAC_BITS-1:0]          lin_q;
  logic [SUM_BITS-1:0]          acc_l, acc_r, left_q, right_q;
  logic [DAC_BITS*CHANNELS-1:0] chan_q;
  logic                         stb_q;

  always_comb begin
    code = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      if (slot == slot_t'(k)) code = bus.log_in[LOG_BITS*k +: LOG_BITS];
    end
  end

`ifdef BHG_PSG_MASTER_ATT_EN
  logic [LOG_BITS-1:0] att2;
  assign att2 = {bus.master_att, 1'b0};
  assign eff  = (code > att2) ? code - att2 : '0;
`else
  logic unused_att;
  assign unused_att = ^bus.master_att;
  assign eff        = code;
`endif

  assign rom_en = bus.clk_en && (slot != LAST);

  bhg_psg_log2lin #(.DAC_BITS(DAC_BITS)) u_log2lin (
    .clk    (clk),
    .rst_n  (rst_n),
    .clk_en (rom_en),
    .addr   (eff),
    .data   (lin_q)
  );

  // Slot 0 publishes the previous frame; slots 1..CHANNELS retire one channel each
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot    <= '0;
      primed  <= 1'b0;
      acc_l   <= '0;
      acc_r   <= '0;
      left_q  <= '0;
      right_q <= '0;
      chan_q  <= '0;
      stb_q   <= 1'b0;
    end else begin
      stb_q <= 1'b0;
      if (bus.clk_en) begin
        slot <= (slot == LAST) ? '0 : slot + slot_t'(1);
        if (slot == '0) begin
          acc_l  <= '0;
          acc_r  <= '0;
          primed <= 1'b1;
          if (primed) begin
            left_q  <= acc_l;
            right_q <= acc_r;
            stb_q   <= 1'b1;
          end
        end else begin
          for (int k = 0; k < CHANNELS; k++) begin
            if (slot == slot_t'(k + 1)) begin
              chan_q[DAC_BITS*k +: DAC_BITS] <= lin_q;
              if (bus.pan_l[k]) acc_l <= acc_l + SUM_BITS'(lin_q);
              if (bus.pan_r[k]) acc_r <= acc_r + SUM_BITS'(lin_q);
            end
          end
        end
      end
    end
  end

  assign bus.chan_lin   = chan_q;
  assign bus.left       = left_q;
  assign bus.right      = right_q;
  assign bus.sample_stb = stb_q;
endmodule

// File: tb/tb_bhg_psg_mixer.sv
// tb/tb_bhg_psg_mixer.sv - randomized check of 3- and 8-channel mixers against a frame-level model
module tb_bhg_psg_mixer;
  logic clk;
  logic rst_n;
  logic en;
  int   en_mode;
  int   n_vec;
  int   n_err;
  int   en_cnt;
  int   clk_cnt;
  logic [4:0] code [8];
  logic [7:0] pl, pr;
  logic [3:0] att;

  bhg_psg_mixer_if #(.CHANNELS(3), .DAC_BITS(10)) bus3 ();
  bhg_psg_mixer_if #(.CHANNELS(8), .DAC_BITS(10)) bus8 ();

  bhg_psg_mixer #(.CHANNELS(3), .DAC_BITS(10)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));
  bhg_psg_mixer #(.CHANNELS(8), .DAC_BITS(10)) dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference level: attenuate in 3 dB steps, then 1.5 dB per code below full scale
  function automatic int model_lin(input int c);
    int e;
    e = c;
`ifdef BHG_PSG_MASTER_ATT_EN
    e = (c > 2 * int'(att)) ? c - 2 * int'(att) : 0;
`endif
    if (e == 0) return 0;
    return $rtoi(1023.0 * (10.0 ** (-0.075 * real'(31 - e))) + 0.5);
  endfunction

  function automatic int lin_of(input int c, input int k);
    if (c == 3) return int'(bus3.chan_lin[10*k +: 10]);
    return int'(bus8.chan_lin[10*k +: 10]);
  endfunction

  function automatic int sum_of(input int c, input bit rgt);
    if (c == 3) return rgt ? int'(bus3.right) : int'(bus3.left);
    return rgt ? int'(bus8.right) : int'(bus8.left);
  endfunction

  function automatic logic stb_of(input int c);
    return (c == 3) ? bus3.sample_stb : bus8.sample_stb;
  endfunction

  task automatic drive();
    for (int k = 0; k < 3; k++) bus3.log_in[5*k +: 5] = code[k];
    for (int k = 0; k < 8; k++) bus8.log_in[5*k +: 5] = code[k];
    bus3.pan_l = pl[2:0];
    bus3.pan_r = pr[2:0];
    bus8.pan_l = pl;
    bus8.pan_r = pr;
    bus3.master_att = att;
    bus8.master_att = att;
  endtask

  task automatic wait_stb(input int c);
    for (int t = 0; t < 400; t++) begin
      @(negedge clk);
      if (stb_of(c)) return;
    end
    chk($sformatf("stb_timeout_c%0d", c), 0, 1);
  endtask

  task automatic compare(input int c, input string tag);
    int e, el, er;
    el = 0;
    er = 0;
    for (int k = 0; k < c; k++) begin
      e = model_lin(int'(code[k]));
      chk($sformatf("%s_c%0d_lin%0d", tag, c, k), lin_of(c, k), e);
      if (pl[k]) el += e;
      if (pr[k]) er += e;
    end
    chk($sformatf("%s_c%0d_left", tag, c), sum_of(c, 1'b0), el);
    chk($sformatf("%s_c%0d_right", tag, c), sum_of(c, 1'b1), er);
  endtask

  task automatic verify(input int c, input string tag);
    wait_stb(c);
    wait_stb(c);
    compare(c, tag);
  endtask

  // Enable pattern: 0 = every clk, 1 = every other clk, 2 = random
  initial begin
    en = 1'b0;
    forever begin
      @(negedge clk);
      case (en_mode)
        0:       en = 1'b1;
        1:       en = ~en;
        default: en = 1'($urandom_range(0, 1));
      endcase
      bus3.clk_en = en;
      bus8.clk_en = en;
    end
  end

  initial begin
    en_cnt  = 0;
    clk_cnt = 0;
    forever begin
      @(posedge clk);
      clk_cnt++;
      if (!rst_n) en_cnt = 0;
      else if (en) en_cnt++;
    end
  end

  // Strobe width and frame period in enables, per design
  initial begin
    bit hp3, hp8, ps3, ps8;
    int pe3, pe8;
    {hp3, hp8, ps3, ps8} = '0;
    pe3 = 0;
    pe8 = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        {hp3, hp8, ps3, ps8} = '0;
      end else begin
        if (bus3.sample_stb) begin
          chk("stb_width_c3", ps3, 0);
          if (hp3) chk("period_c3", en_cnt - pe3, 4);
          pe3 = en_cnt;
          hp3 = 1'b1;
        end
        if (bus8.sample_stb) begin
          chk("stb_width_c8", ps8, 0);
          if (hp8) chk("period_c8", en_cnt - pe8, 9);
          pe8 = en_cnt;
          hp8 = 1'b1;
        end
        ps3 = bus3.sample_stb;
        ps8 = bus8.sample_stb;
      end
    end
  end

  initial begin
    int t0;
    n_vec   = 0;
    n_err   = 0;
    en_mode = 0;
    rst_n   = 1'b1;
    for (int k = 0; k < 8; k++) code[k] = '0;
    pl  = '0;
    pr  = '0;
    att = '0;
    bus3.clk_en = 1'b0;
    bus8.clk_en = 1'b0;
    drive();
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_chan_c3", bus3.chan_lin, 0);
    chk("rst_left_c3", bus3.left, 0);
    chk("rst_right_c3", bus3.right, 0);
    chk("rst_stb_c3", bus3.sample_stb, 0);
    chk("rst_chan_c8", (bus8.chan_lin == '0), 1);
    chk("rst_left_c8", bus8.left, 0);
    rst_n = 1'b1;

    for (int k = 0; k < 8; k++) code[k] = 5'd31;
    pl = 8'hff;
    pr = 8'hff;
    drive();
    verify(3, "full");
    chk("full_c3_left_abs", sum_of(3, 1'b0), 3069);
    chk("full_c3_right_abs", sum_of(3, 1'b1), 3069);
    verify(8, "full");
    chk("full_c8_left_abs", sum_of(8, 1'b0), 8184);
    chk("full_c8_right_abs", sum_of(8, 1'b1), 8184);

    code[0] = 5'd31; code[1] = 5'd27; code[2] = 5'd0;
    pl = 8'h01;
    pr = 8'h06;
    drive();
    verify(3, "pan");
    chk("pan_lin1_abs", lin_of(3, 1), 513);
    chk("pan_left_abs", sum_of(3, 1'b0), 1023);
    chk("pan_right_abs", sum_of(3, 1'b1), 513);

    code[1] = 5'd3;
    att = 4'd2;
    drive();
    verify(3, "att");
`ifdef BHG_PSG_MASTER_ATT_EN
    chk("att_log31_abs", lin_of(3, 0), 513);
    chk("att_log3_abs", lin_of(3, 1), 0);
`else
    chk("att_log31_abs", lin_of(3, 0), 1023);
    chk("att_log3_abs", lin_of(3, 1), 8);
`endif

    en_mode = 1;
    for (int k = 0; k < 8; k++) code[k] = 5'($urandom_range(0, 31));
    pl = 8'($urandom);
    pr = 8'($urandom);
    drive();
    verify(3, "half");
    wait_stb(3);
    t0 = clk_cnt;
    wait_stb(3);
    chk("half_frame_clks", clk_cnt - t0, 8);
    compare(3, "half2");

    for (int i = 0; i < 36; i++) begin
      en_mode = i % 3;
      for (int k = 0; k < 8; k++) code[k] = 5'($urandom_range(0, 31));
      pl  = 8'($urandom);
      pr  = 8'($urandom);
      att = 4'($urandom_range(0, 15));
      drive();
      verify(3, $sformatf("rnd%0d", i));
      verify(8, $sformatf("rnd%0d", i));
    end

    en_mode = 0;
    att = '0;
    for (int k = 0; k < 8; k++) code[k] = 5'($urandom_range(1, 31));
    pl = 8'hff;
    pr = 8'hff;
    drive();
    verify(3, "pre_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_chan_c3", bus3.chan_lin, 0);
    chk("mid_rst_left_c3", bus3.left, 0);
    chk("mid_rst_right_c3", bus3.right, 0);
    chk("mid_rst_stb_c3", bus3.sample_stb, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_stb(3);
    chk("post_rst_first_stb_enables", en_cnt, 5);
    compare(3, "post_rst");
    verify(8, "post_rst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/bhg_psg_mixer.md
# bhg_psg_mixer

Parametrised N-channel log-volume mixer for the PSG sound path; successor to the fixed three-channel A/B/C output sequencer. Takes per-channel 5-bit log volume codes from the tone, noise and envelope logic. Time-multiplexes them through one log-to-linear table and produces per-channel linear levels plus independently panned left/right sums. Adds configurable channel count, stereo panning and an optional master attenuation.

## Interface
- CHANNELS, 3, number of channels, 1..8
- DAC_BITS, 10, linear output width per channel, 8..14
- SUM_BITS, DAC_BITS+$clog2(CHANNELS+1), derived, sum width; not overridden
- clk  in  1  system clock, all logic on posedge
- rst_n  in  1  reset, asynchronous, active-low
- clk_en  in  1  clock enable; all state advances only when high
- log_in  in  5*CHANNELS  per-channel log code, channel k at [5k+4:5k]; 0 = silent, 31 = full scale
- pan_l  in  CHANNELS  bit k routes channel k to the left sum
- pan_r  in  CHANNELS  bit k routes channel k to the right sum
- master_att  in  4  attenuation, 2 log codes (3 dB) per step
- chan_lin  out  DAC_BITS*CHANNELS  per-channel linear level, channel k at [DAC_BITS*k +: DAC_BITS]
- left  out  SUM_BITS  left sum
- right  out  SUM_BITS  right sum
- sample_stb  out  1  one-clk pulse when left/right update

## Operation
- slot counter 0..CHANNELS, advances on every clk_en, wraps CHANNELS->0; one frame = CHANNELS+1 enables.
- Effective code: eff = log_in[k] > 2*master_att ? log_in[k]-2*master_att : 0. Codes attenuated to 0 or below are silent.
- Slot s < CHANNELS: lin_q <= table[eff of channel s]; log_in[s] sampled here.
- Slot s in 1..CHANNELS: chan_lin[s-1] <= lin_q. acc_l += pan_l[s-1] ? lin_q : 0. acc_r likewise with pan_r. Pan bits are sampled in this slot.
- Slot 0: left <= acc_l, right <= acc_r, acc_l/acc_r <= 0, sample_stb <= 1. Exception: the first slot 0 after reset publishes nothing and does not strobe.
- Table: code 0 -> 0. Code n (1..31) -> round((2^DAC_BITS-1) * 10^(-(31-n)*1.5/20)). Code 31 -> all ones.
- Widths: accumulators are SUM_BITS wide, zero-extend lin_q, and cannot overflow. No saturation logic.

## Timing
- Reset values: chan_lin, left, right, sample_stb, lin_q, acc_l, acc_r all 0; slot 0; prime flag cleared.
- Reset is asynchronous; asserting it mid-frame discards the partial frame.
- Latency: log_in[k] sampled at slot k -> chan_lin[k] valid after slot k+1 edge -> included in left/right after the next slot-0 edge.
- Worst case from input change to sum: 2*(CHANNELS+1) enables.
- sample_stb is high exactly one clk cycle after the publishing slot-0 edge. It clears on the next clk edge regardless of clk_en.
- With clk_en low, all state holds except sample_stb clearing.
- Inputs may change at any time. Each channel's value is the one present at its own slot, so no frame-wide snapshot is guaranteed.

## Configuration
- BHG_PSG_MASTER_ATT_EN defined: master_att applied as above.
- BHG_PSG_MASTER_ATT_EN undefined: master_att port still present but ignored, eff = log_in[k], and no subtractor is built.

## Structure
- Shared package bhg_psg_pkg:
  - LOG_BITS = 5 and the table-generation constant function.
  - Slot index type sized $clog2(CHANNELS+1).
- One sub-module, bhg_psg_log2lin: parameter DAC_BITS, registered 32-entry ROM with clk_en, 5-bit address in, DAC_BITS out, one-enable latency.
- Slot counter, accumulators and output registers live in bhg_psg_mixer.

## Test plan
- CHANNELS=3, DAC_BITS=10, all log_in=31, pan_l=pan_r=111, att=0 -> chan_lin all 1023, left=right=3069, sample_stb every 4th enable.
- log_in ch0=31, ch1=27, ch2=0; pan_l=001, pan_r=110 -> chan_lin = 1023, 513, 0; left=1023, right=513.
- Macro defined, att=2:
  - log 31 -> chan_lin 513.
  - log 3 -> 0.
  - Macro undefined, att=2: log 31 -> 1023.
- clk_en high every other clk -> frame spans 8 clks, sample_stb exactly 1 clk wide, sums unchanged vs. full-rate run.
- rst_n pulsed low mid-frame with nonzero sums:
  - All outputs 0 immediately.
  - First post-reset slot 0 gives no strobe.
  - The following frame publishes correct sums.
- CHANNELS=8, DAC_BITS=10, all log_in=31, pan both -> SUM_BITS=14, left=right=8184, frame period 9 enables.
